// File: rtl/hqm_aw_lifo_pop_arb.sv
// ---------------------------------------------------------------------------
// hqm_aw_lifo_pop_arb
//
// Round-robin pop scheduler that shares one LIFO free-list among NUM_REQ
// requesters plus a single push (return) port. At most one pop is issued per
// cycle. The granted requester id rides a RD_LAT-deep tracking pipe, so the
// popped entry comes back tagged with the requester id that asked for it.
//
// Parameters
//   NUM_REQ  number of pop requesters (>= 2)
//   DWIDTH   LIFO entry width
//   RD_LAT   cycles from lifo_pop_o to valid lifo_pop_data_i (>= 1)
//   IDW      requester id width (derived)
//
// Ports
//   clk_i             clock
//   rst_n_i           asynchronous active-low reset
//   cfg_req_mask_i    1 = requester enabled; masked requesters never win
//   req_v_i           per-requester pop request, held until granted
//   req_gnt_o         one-hot combinational grant (pop taken this cycle)
//   push_v_i          return an entry to the free-list
//   push_data_i       returned entry
//   push_rdy_o        push accepted when push_v_i & push_rdy_o
//   rsp_v_o           popped data valid
//   rsp_id_o          requester id owning rsp_data_o
//   rsp_data_o        popped entry (zero when rsp_v_o is low)
//   lifo_push_o       push strobe to LIFO control
//   lifo_push_data_o  push data to LIFO control
//   lifo_pop_o        pop strobe to LIFO control
//   lifo_pop_data_i   pop data from LIFO control, RD_LAT cycles after pop
//   lifo_full_i       LIFO full flag (flopped in LIFO control)
//   lifo_empty_i      LIFO empty flag (flopped in LIFO control)
//   status_idle_o     nothing eligible and nothing in flight
//   error_ovf_o       one-cycle pulse: push attempted while full (dropped)
// ---------------------------------------------------------------------------
module hqm_aw_lifo_pop_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned RD_LAT  = 2,
    localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_REQ-1:0] cfg_req_mask_i,
    input  logic [NUM_REQ-1:0] req_v_i,
    output logic [NUM_REQ-1:0] req_gnt_o,
    input  logic               push_v_i,
    input  logic [DWIDTH-1:0]  push_data_i,
    output logic               push_rdy_o,
    output logic               rsp_v_o,
    output logic [IDW-1:0]     rsp_id_o,
    output logic [DWIDTH-1:0]  rsp_data_o,
    output logic               lifo_push_o,
    output logic [DWIDTH-1:0]  lifo_push_data_o,
    output logic               lifo_pop_o,
    input  logic [DWIDTH-1:0]  lifo_pop_data_i,
    input  logic               lifo_full_i,
    input  logic               lifo_empty_i,
    output logic               status_idle_o,
    output logic               error_ovf_o
);

    localparam logic [IDW-1:0] RR_RESET = IDW'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_id;
    logic               gnt_any;

    logic [IDW-1:0]     rr_ptr_q;
    logic [IDW-1:0]     rr_ptr_d;

    logic [RD_LAT-1:0]  pipe_v_q;
    logic [IDW-1:0]     pipe_id_q [RD_LAT];

    assign elig = req_v_i & cfg_req_mask_i;

    // Round-robin search starting one past the last winner. The empty flag
    // is flopped in the LIFO and updates the cycle after a pop, so gating on
    // it here is enough to keep the LIFO from ever underflowing. The grant is
    // also held off while in reset so no pop can leak out of a reset window.
    always_comb begin
        int unsigned cand;
        logic        found;
        cand   = 0;
        found  = 1'b0;
        gnt    = '0;
        gnt_id = '0;
        if (rst_n_i && !lifo_empty_i) begin
            for (int unsigned i = 1; i <= NUM_REQ; i++) begin
                cand = 32'(rr_ptr_q) + i;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                if (!found && elig[cand[IDW-1:0]]) begin
                    found                 = 1'b1;
                    gnt[cand[IDW-1:0]]    = 1'b1;
                    gnt_id                = cand[IDW-1:0];
                end
            end
        end
    end

    assign gnt_any  = |gnt;
    assign rr_ptr_d = gnt_any ? gnt_id : rr_ptr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr_q <= RR_RESET;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Tracking pipe: stage 0 captures the pop and its owner; the last stage
    // lines up with lifo_pop_data_i, so responses leave in grant order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pipe_v_q <= '0;
            for (int unsigned s = 0; s < RD_LAT; s++) begin
                pipe_id_q[s] <= '0;
            end
        end else begin
            pipe_v_q[0]  <= gnt_any;
            pipe_id_q[0] <= gnt_id;
            for (int unsigned s = 1; s < RD_LAT; s++) begin
                pipe_v_q[s]  <= pipe_v_q[s-1];
                pipe_id_q[s] <= pipe_id_q[s-1];
            end
        end
    end

    assign req_gnt_o  = gnt;
    assign lifo_pop_o = gnt_any;

    assign rsp_v_o    = pipe_v_q[RD_LAT-1];
    assign rsp_id_o   = pipe_id_q[RD_LAT-1];
    assign rsp_data_o = pipe_v_q[RD_LAT-1] ? lifo_pop_data_i : '0;

    // A push coinciding with a pop is forwarded unchanged; the LIFO decides
    // that the pushed entry is what the pop returns.
    assign push_rdy_o       = ~lifo_full_i;
    assign lifo_push_o      = push_v_i & ~lifo_full_i;
    assign lifo_push_data_o = push_data_i;
    assign error_ovf_o      = push_v_i & lifo_full_i;

    assign status_idle_o = ~(|elig) & ~(|pipe_v_q);

endmodule

// File: tb/tb_hqm_aw_lifo_pop_arb.sv
module tb_hqm_aw_lifo_pop_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cfg_req_mask;
    logic [3:0]  req_v;
    logic [3:0]  req_gnt;
    logic        push_v;
    logic [15:0] push_data;
    logic        push_rdy;
    logic        rsp_v;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        lifo_push;
    logic [15:0] lifo_push_data;
    logic        lifo_pop;
    logic [15:0] lifo_pop_data;
    logic        lifo_full;
    logic        lifo_empty;
    logic        status_idle;
    logic        error_ovf;

    int n_tot  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hqm_aw_lifo_pop_arb #(.NUM_REQ(4), .DWIDTH(16), .RD_LAT(2)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .cfg_req_mask_i   (cfg_req_mask),
        .req_v_i          (req_v),
        .req_gnt_o        (req_gnt),
        .push_v_i         (push_v),
        .push_data_i      (push_data),
        .push_rdy_o       (push_rdy),
        .rsp_v_o          (rsp_v),
        .rsp_id_o         (rsp_id),
        .rsp_data_o       (rsp_data),
        .lifo_push_o      (lifo_push),
        .lifo_push_data_o (lifo_push_data),
        .lifo_pop_o       (lifo_pop),
        .lifo_pop_data_i  (lifo_pop_data),
        .lifo_full_i      (lifo_full),
        .lifo_empty_i     (lifo_empty),
        .status_idle_o    (status_idle),
        .error_ovf_o      (error_ovf)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  mask;
        logic        empty;
        logic        full;
        logic        push_v;
        logic [15:0] push_d;
        logic [15:0] pop_d;
        logic [3:0]  e_gnt;
        logic        e_rsp_v;
        logic [1:0]  e_rsp_id;
        logic        e_push;
        logic        e_rdy;
        logic        e_ovf;
        logic        e_idle;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(
        input logic [3:0] req, input logic [3:0] mask, input logic empty,
        input logic full, input logic pv, input logic [15:0] pd,
        input logic [15:0] popd, input logic [3:0] eg, input logic erv,
        input logic [1:0] eid, input logic ep, input logic er,
        input logic eo, input logic ei);
        vec_t v;
        v.req = req; v.mask = mask; v.empty = empty; v.full = full;
        v.push_v = pv; v.push_d = pd; v.pop_d = popd;
        v.e_gnt = eg; v.e_rsp_v = erv; v.e_rsp_id = eid;
        v.e_push = ep; v.e_rdy = er; v.e_ovf = eo; v.e_idle = ei;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           req     mask    emp full pv  push_d    pop_d     gnt     rv  id     push rdy ovf idle
        // round-robin over all four after reset
        tbl[0]  = mk(4'hF,  4'hF,  0,  0,  0, 16'h0000, 16'hD000, 4'b0001, 0, 2'd0, 0, 1, 0, 0);
        tbl[1]  = mk(4'hF,  4'hF,  0,  0,  0, 16'h0000, 16'hD001, 4'b0010, 0, 2'd0, 0, 1, 0, 0);
        tbl[2]  = mk(4'hF,  4'hF,  0,  0,  0, 16'h0000, 16'hD002, 4'b0100, 1, 2'd0, 0, 1, 0, 0);
        tbl[3]  = mk(4'hF,  4'hF,  0,  0,  0, 16'h0000, 16'hD003, 4'b1000, 1, 2'd1, 0, 1, 0, 0);
        tbl[4]  = mk(4'hF,  4'hF,  0,  0,  0, 16'h0000, 16'hD004, 4'b0001, 1, 2'd2, 0, 1, 0, 0);
        tbl[5]  = mk(4'h0,  4'hF,  0,  0,  0, 16'h0000, 16'hD005, 4'b0000, 1, 2'd3, 0, 1, 0, 0);
        tbl[6]  = mk(4'h0,  4'hF,  0,  0,  0, 16'h0000, 16'hD006, 4'b0000, 1, 2'd0, 0, 1, 0, 0);
        tbl[7]  = mk(4'h0,  4'hF,  0,  0,  0, 16'h0000, 16'hD007, 4'b0000, 0, 2'd0, 0, 1, 0, 1);
        // park pointer on 3, then stall on empty: pointer must hold
        tbl[8]  = mk(4'h8,  4'hF,  0,  0,  0, 16'h0000, 16'hD008, 4'b1000, 0, 2'd0, 0, 1, 0, 0);
        tbl[9]  = mk(4'h5,  4'hF,  1,  0,  0, 16'h0000, 16'hD009, 4'b0000, 0, 2'd0, 0, 1, 0, 0);
        tbl[10] = mk(4'h5,  4'hF,  1,  0,  0, 16'h0000, 16'hD00A, 4'b0000, 1, 2'd3, 0, 1, 0, 0);
        tbl[11] = mk(4'h5,  4'hF,  0,  0,  0, 16'h0000, 16'hD00B, 4'b0001, 0, 2'd0, 0, 1, 0, 0);
        // requester 2 masked off
        tbl[12] = mk(4'hF,  4'hB,  0,  0,  0, 16'h0000, 16'hD00C, 4'b0010, 0, 2'd0, 0, 1, 0, 0);
        tbl[13] = mk(4'hF,  4'hB,  0,  0,  0, 16'h0000, 16'hD00D, 4'b1000, 1, 2'd0, 0, 1, 0, 0);
        tbl[14] = mk(4'hF,  4'hB,  0,  0,  0, 16'h0000, 16'hD00E, 4'b0001, 1, 2'd1, 0, 1, 0, 0);
        tbl[15] = mk(4'hF,  4'hB,  0,  0,  0, 16'h0000, 16'hD00F, 4'b0010, 1, 2'd3, 0, 1, 0, 0);
        tbl[16] = mk(4'h4,  4'hB,  0,  0,  0, 16'h0000, 16'hD010, 4'b0000, 1, 2'd0, 0, 1, 0, 0);
        tbl[17] = mk(4'h4,  4'hB,  0,  0,  0, 16'h0000, 16'hD011, 4'b0000, 1, 2'd1, 0, 1, 0, 0);
        tbl[18] = mk(4'h4,  4'hB,  0,  0,  0, 16'h0000, 16'hD012, 4'b0000, 0, 2'd0, 0, 1, 0, 1);
        // push against full, normal push, full without push
        tbl[19] = mk(4'h0,  4'hF,  0,  1,  1, 16'h1234, 16'hD013, 4'b0000, 0, 2'd0, 0, 0, 1, 1);
        tbl[20] = mk(4'h0,  4'hF,  0,  0,  1, 16'h5555, 16'hD014, 4'b0000, 0, 2'd0, 1, 1, 0, 1);
        tbl[21] = mk(4'h0,  4'hF,  0,  1,  0, 16'h0000, 16'hD015, 4'b0000, 0, 2'd0, 0, 0, 0, 1);
        // push 0xABCD with a pop for requester 1 in the same cycle
        tbl[22] = mk(4'h2,  4'hF,  0,  0,  1, 16'hABCD, 16'hD016, 4'b0010, 0, 2'd0, 1, 1, 0, 0);
        tbl[23] = mk(4'h0,  4'hF,  0,  0,  0, 16'h0000, 16'hD017, 4'b0000, 0, 2'd0, 0, 1, 0, 0);
        tbl[24] = mk(4'h0,  4'hF,  0,  0,  0, 16'h0000, 16'hABCD, 4'b0000, 1, 2'd1, 0, 1, 0, 0);
        tbl[25] = mk(4'h0,  4'hF,  0,  0,  0, 16'h0000, 16'hD019, 4'b0000, 0, 2'd0, 0, 1, 0, 1);

        rst_n = 1'b0; cfg_req_mask = 4'hF; req_v = 4'h0; push_v = 1'b0;
        push_data = '0; lifo_pop_data = 16'hBEEF; lifo_full = 1'b0; lifo_empty = 1'b0;
        tick(); tick();

        chk("rst_gnt",   32'(req_gnt), 32'h0);
        chk("rst_pop",   32'(lifo_pop), 32'h0);
        chk("rst_push",  32'(lifo_push), 32'h0);
        chk("rst_rsp_v", 32'(rsp_v), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_ovf",   32'(error_ovf), 32'h0);
        chk("rst_idle",  32'(status_idle), 32'h1);
        req_v = 4'hF;
        #1;
        chk("rst_gnt_held", 32'(req_gnt), 32'h0);
        req_v = 4'h0;
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            cfg_req_mask  = tbl[i].mask;
            req_v         = tbl[i].req;
            lifo_empty    = tbl[i].empty;
            lifo_full     = tbl[i].full;
            push_v        = tbl[i].push_v;
            push_data     = tbl[i].push_d;
            lifo_pop_data = tbl[i].pop_d;
            #2;
            chk($sformatf("v%0d_gnt", i),  32'(req_gnt), 32'(tbl[i].e_gnt));
            chk($sformatf("v%0d_pop", i),  32'(lifo_pop), 32'(|tbl[i].e_gnt));
            chk($sformatf("v%0d_rsp_v", i), 32'(rsp_v), 32'(tbl[i].e_rsp_v));
            chk($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(tbl[i].e_rsp_id));
            chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data),
                tbl[i].e_rsp_v ? 32'(tbl[i].pop_d) : 32'h0);
            chk($sformatf("v%0d_push", i), 32'(lifo_push), 32'(tbl[i].e_push));
            if (tbl[i].push_v)
                chk($sformatf("v%0d_push_data", i), 32'(lifo_push_data), 32'(tbl[i].push_d));
            chk($sformatf("v%0d_rdy", i),  32'(push_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_ovf", i),  32'(error_ovf), 32'(tbl[i].e_ovf));
            chk($sformatf("v%0d_idle", i), 32'(status_idle), 32'(tbl[i].e_idle));
            tick();
        end

        // reset with two pops in flight; pointer moved off 3 beforehand
        cfg_req_mask = 4'hF; lifo_empty = 1'b0; lifo_full = 1'b0; push_v = 1'b0;
        lifo_pop_data = 16'h7777;
        req_v = 4'hF;
        #1;
        chk("r6_gnt_a", 32'(req_gnt), 32'b0100);
        tick();
        req_v = 4'h2;
        #1;
        chk("r6_gnt_b", 32'(req_gnt), 32'b0010);
        tick();
        req_v = 4'hF;
        rst_n = 1'b0;
        #1;
        chk("r6_in_rst_gnt", 32'(req_gnt), 32'h0);
        chk("r6_in_rst_rsp_v", 32'(rsp_v), 32'h0);
        tick();
        rst_n = 1'b1;
        req_v = 4'h0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("r6_post_rsp_v%0d", c), 32'(rsp_v), 32'h0);
            chk($sformatf("r6_post_rsp_data%0d", c), 32'(rsp_data), 32'h0);
            chk($sformatf("r6_post_idle%0d", c), 32'(status_idle), 32'h1);
            tick();
        end
        req_v = 4'hF;
        #1;
        chk("r6_first_gnt", 32'(req_gnt), 32'b0001);
        tick();
        req_v = 4'h0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
